// File: rtl/cmd_copy_opt_multi_pkg.sv
// cmd_copy_opt_pkg: shared states, flag positions and flag-update helpers for the copy-flag optimiser
package cmd_copy_opt_pkg;
  typedef enum logic [3:0] {
    IDLE, RD_NADDR, RD_CADDR, CMP, RD_CFLG, RD_NFLG, WR_CUR, WR_NEXT, DONE
  } state_t;
  localparam int FLG_COPY_IN  = 4;
  localparam int FLG_COPY_OUT = 5;
  localparam int FLG_REUSE    = 7;
  function automatic logic [2:0] hdr_words(input logic [1:0] cmd_type);
    return cmd_type == 2'd0 ? 3'd3 : 3'd4;
  endfunction
  function automatic logic [15:0] upd_flags(input logic [7:0] c, input logic [7:0] n);
    logic [7:0] cu, nu;
    logic keep;
    keep = n[FLG_COPY_IN] & ~c[FLG_REUSE] & ~c[FLG_COPY_IN];
    cu = c;
    cu[FLG_COPY_OUT] = c[FLG_COPY_OUT] & ~n[FLG_COPY_OUT];
    nu = n;
    nu[FLG_COPY_IN] = keep;
    nu[FLG_REUSE] = n[FLG_COPY_IN] & ~keep;
    return {cu, nu};
  endfunction
endpackage

// File: rtl/cmd_copy_opt_multi_if.sv
// cmd_copy_opt_multi_if: control handshake and shared subqueue memory bus of the optimiser
interface cmd_copy_opt_multi_if #(
  parameter int SUBQUEUE_BITS = 6,
  parameter int NUM_QUEUES    = 2,
  parameter int ARG_CNT_W     = 4,
  parameter int QSEL_W        = 1
);
  logic [SUBQUEUE_BITS-1:0] q_addr;
  logic [NUM_QUEUES-1:0]    q_en;
  logic [7:0]               q_we;
  logic [63:0]              q_din;
  logic [NUM_QUEUES*64-1:0] q_dout;
  logic                     start;
  logic                     busy;
  logic                     finished;
  logic [QSEL_W-1:0]        queue_select;
  logic [1:0]               cmd_type;
  logic                     full_match;
  logic [SUBQUEUE_BITS-1:0] first_idx;
  logic [SUBQUEUE_BITS-1:0] first_next_idx;
  logic [ARG_CNT_W-1:0]     num_args_cur;
  logic [ARG_CNT_W-1:0]     num_args_next;
  logic [ARG_CNT_W-1:0]     match_count;
  modport master (
    output q_addr, q_en, q_we, q_din, busy, finished, match_count,
    input  q_dout, start, queue_select, cmd_type, full_match,
           first_idx, first_next_idx, num_args_cur, num_args_next
  );
  modport slave (
    input  q_addr, q_en, q_we, q_din, busy, finished, match_count,
    output q_dout, start, queue_select, cmd_type, full_match,
           first_idx, first_next_idx, num_args_cur, num_args_next
  );
endinterface

// File: rtl/cmd_copy_opt_multi_arg_iter.sv
// cmd_arg_iter: i/j argument counters with positional or any-to-any loop control and word index generation
module cmd_arg_iter #(
  parameter int SUBQUEUE_BITS = 6,
  parameter int ARG_CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     load,
  input  logic                     step,
  input  logic                     matched,
  input  logic                     full,
  input  logic [ARG_CNT_W-1:0]     n_cur,
  input  logic [ARG_CNT_W-1:0]     n_next,
  input  logic [SUBQUEUE_BITS-1:0] base_cur,
  input  logic [SUBQUEUE_BITS-1:0] base_next,
  output logic [SUBQUEUE_BITS-1:0] cur_flg,
  output logic [SUBQUEUE_BITS-1:0] cur_adr,
  output logic [SUBQUEUE_BITS-1:0] nxt_flg,
  output logic [SUBQUEUE_BITS-1:0] nxt_adr,
  output logic                     inner_more,
  output logic                     exhausted
);
  logic [ARG_CNT_W-1:0] i, j, nc, lim, i_nx, j_nx;
  logic [SUBQUEUE_BITS-1:0] bc, bn;
  logic fm;
  assign i_nx = i + ARG_CNT_W'(1);
  assign j_nx = j + ARG_CNT_W'(1);
  assign inner_more = fm && !matched && (i_nx < nc);
  assign exhausted = !inner_more && (j_nx >= lim);
  assign cur_flg = bc + (SUBQUEUE_BITS'(i) << 1);
  assign cur_adr = cur_flg + SUBQUEUE_BITS'(1);
  assign nxt_flg = bn + (SUBQUEUE_BITS'(j) << 1);
  assign nxt_adr = nxt_flg + SUBQUEUE_BITS'(1);
  // counters: positional mode keeps i locked to j; full mode sweeps i per j
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i <= '0;
      j <= '0;
      nc <= '0;
      lim <= '0;
      fm <= 1'b0;
      bc <= '0;
      bn <= '0;
    end else if (load) begin
      i <= '0;
      j <= '0;
      nc <= n_cur;
      fm <= full;
      lim <= full ? n_next : (n_next < n_cur ? n_next : n_cur);
      bc <= base_cur;
      bn <= base_next;
    end else if (step) begin
      i <= inner_more ? i_nx : (fm ? '0 : j_nx);
      j <= inner_more ? j : j_nx;
    end
  end
endmodule

// File: rtl/cmd_copy_opt_multi.sv
// cmd_copy_opt_multi: rewrites copy/reuse flags of matching arguments in consecutive queued commands
module cmd_copy_opt_multi
  import cmd_copy_opt_pkg::*;
#(
  parameter int SUBQUEUE_BITS = 6,
  parameter int NUM_QUEUES    = 2,
  parameter int MAX_ARGS      = 15,
  parameter int ARG_CNT_W     = $clog2(MAX_ARGS + 1),
  parameter int QSEL_W        = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input logic clk,
  input logic rstn,
  cmd_copy_opt_multi_if.master bus
);
  state_t state, nxt, after;
  logic [QSEL_W-1:0] qsel;
  logic [63:0] addr_n, dout;
  logic [7:0] c_flg, n_flg;
  logic [15:0] upd;
  logic [SUBQUEUE_BITS-1:0] cur_flg, cur_adr, nxt_flg, nxt_adr;
  logic [ARG_CNT_W-1:0] mcnt;
  logic naddr_q, acc, we, hit, load, step, inner_more, exhausted;
  assign dout = bus.q_dout[64*qsel +: 64];
  assign hit = dout == addr_n;
  assign load = state == IDLE && bus.start;
  assign step = (state == CMP && !hit) || state == WR_NEXT;
  assign upd = upd_flags(c_flg, state == WR_CUR ? dout[7:0] : n_flg);
  assign bus.q_en = acc ? NUM_QUEUES'(1) << qsel : '0;
  assign bus.q_we = we ? 8'h01 : 8'h00;
  assign bus.busy = state != IDLE && state != DONE;
  assign bus.finished = state == DONE;
  assign bus.match_count = mcnt;
  cmd_arg_iter #(.SUBQUEUE_BITS(SUBQUEUE_BITS), .ARG_CNT_W(ARG_CNT_W)) u_iter (
    .clk(clk),
    .rstn(rstn),
    .load(load),
    .step(step),
    .matched(state == WR_NEXT),
    .full(bus.full_match),
    .n_cur(bus.num_args_cur),
    .n_next(bus.num_args_next),
    .base_cur(bus.first_idx + SUBQUEUE_BITS'(hdr_words(bus.cmd_type))),
    .base_next(bus.first_next_idx + SUBQUEUE_BITS'(hdr_words(bus.cmd_type))),
    .cur_flg(cur_flg),
    .cur_adr(cur_adr),
    .nxt_flg(nxt_flg),
    .nxt_adr(nxt_adr),
    .inner_more(inner_more),
    .exhausted(exhausted)
  );
  // state register plus captured address/flag operands and match counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      qsel <= '0;
      mcnt <= '0;
      addr_n <= '0;
      c_flg <= '0;
      n_flg <= '0;
      naddr_q <= 1'b0;
    end else begin
      state <= nxt;
      naddr_q <= state == RD_NADDR;
      if (load) qsel <= bus.queue_select;
      if (load) mcnt <= '0;
      else if (state == CMP && hit) mcnt <= mcnt + ARG_CNT_W'(1);
      if (state == RD_CADDR && naddr_q) addr_n <= dout;
      if (state == RD_NFLG) c_flg <= dout[7:0];
      if (state == WR_CUR) n_flg <= dout[7:0];
    end
  end
  // next state and memory access decode
  always_comb begin
    nxt = state;
    acc = 1'b0;
    we = 1'b0;
    bus.q_addr = '0;
    bus.q_din = '0;
    after = exhausted ? DONE : (inner_more ? RD_CADDR : RD_NADDR);
    case (state)
      IDLE:     nxt = !bus.start ? IDLE : ((bus.num_args_cur == '0 || bus.num_args_next == '0) ? DONE : RD_NADDR);
      RD_NADDR: begin
        acc = 1'b1;
        bus.q_addr = nxt_adr;
        nxt = RD_CADDR;
      end
      RD_CADDR: begin
        acc = 1'b1;
        bus.q_addr = cur_adr;
        nxt = CMP;
      end
      CMP:      nxt = hit ? RD_CFLG : after;
      RD_CFLG:  begin
        acc = 1'b1;
        bus.q_addr = cur_flg;
        nxt = RD_NFLG;
      end
      RD_NFLG:  begin
        acc = 1'b1;
        bus.q_addr = nxt_flg;
        nxt = WR_CUR;
      end
      WR_CUR:   begin
        acc = 1'b1;
        we = 1'b1;
        bus.q_addr = cur_flg;
        bus.q_din = {56'b0, upd[15:8]};
        nxt = WR_NEXT;
      end
      WR_NEXT:  begin
        acc = 1'b1;
        we = 1'b1;
        bus.q_addr = nxt_flg;
        bus.q_din = {56'b0, upd[7:0]};
        nxt = after;
      end
      default:  nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cmd_copy_opt_multi.sv
// tb_cmd_copy_opt_multi: randomized and directed checks of the copy-flag optimiser against a behavioural model
module tb_cmd_copy_opt_multi;
  localparam int SB = 6;
  localparam int NQ = 2;
  localparam int AW = 4;
  localparam int QW = 1;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  cmd_copy_opt_multi_if #(.SUBQUEUE_BITS(SB), .NUM_QUEUES(NQ), .ARG_CNT_W(AW), .QSEL_W(QW)) bus();
  cmd_copy_opt_multi #(.SUBQUEUE_BITS(SB), .NUM_QUEUES(NQ), .MAX_ARGS(15), .ARG_CNT_W(AW), .QSEL_W(QW)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );
  logic [63:0] mem [NQ][DEPTH];
  logic [63:0] exp_mem [NQ][DEPTH];
  logic [63:0] pool [4];
  logic [NQ*64-1:0] dout_q;
  logic ld;
  int ld_q, ld_a;
  logic [63:0] ld_d;
  logic [NQ-1:0] obs_en [$];
  logic [7:0] obs_we [$];
  int n_chk = 0;
  int n_fail = 0;
  assign bus.q_dout = dout_q;
  // subqueue memories: 1-cycle read latency, byte-enabled writes, plus a backdoor load port
  always @(posedge clk) begin
    if (ld) mem[ld_q][ld_a] <= ld_d;
    for (int k = 0; k < NQ; k++) if (bus.q_en[k]) begin
      for (int b = 0; b < 8; b++) if (bus.q_we[b]) mem[k][bus.q_addr][8*b +: 8] <= bus.q_din[8*b +: 8];
      dout_q[64*k +: 64] <= mem[k][bus.q_addr];
    end
  end
  // record every memory access cycle for later enable/strobe checks
  always @(negedge clk) if (rstn && bus.q_en != '0) begin
    obs_en.push_back(bus.q_en);
    obs_we.push_back(bus.q_we);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic poke(input int q, input int a, input logic [63:0] d);
    ld = 1'b1;
    ld_q = q;
    ld_a = a % DEPTH;
    ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask
  task automatic set_arg(input int q, input int base, input int i, input logic [7:0] f, input logic [63:0] a);
    poke(q, base + 2*i, {$urandom, $urandom_range(0, 255)} & 64'hFFFF_FFFF_FFFF_FF00 | 64'(f));
    poke(q, base + 2*i + 1, a);
  endtask
  task automatic cmp_mem(input string tag);
    for (int k = 0; k < NQ; k++)
      for (int a = 0; a < DEPTH; a++)
        chk($sformatf("%s mem[%0d][%0d]", tag, k, a), mem[k][a], exp_mem[k][a]);
  endtask
  task automatic model(input int q, input int ct, input int fm, input int fi, input int fni,
                       input int nc, input int nn, output int cnt);
    int bc, bn, cf, nf;
    logic [63:0] na;
    logic [7:0] c, n, c2, n2;
    logic keep;
    bc = fi + (ct == 0 ? 3 : 4);
    bn = fni + (ct == 0 ? 3 : 4);
    cnt = 0;
    for (int j = 0; j < nn; j++) begin
      na = exp_mem[q][(bn + 2*j + 1) % DEPTH];
      for (int i = (fm != 0 ? 0 : j); i < (fm != 0 ? nc : (j < nc ? j + 1 : 0)); i++) begin
        if (exp_mem[q][(bc + 2*i + 1) % DEPTH] == na) begin
          cf = (bc + 2*i) % DEPTH;
          nf = (bn + 2*j) % DEPTH;
          c = exp_mem[q][cf][7:0];
          n = exp_mem[q][nf][7:0];
          keep = n[4] & ~c[7] & ~c[4];
          c2 = c;
          c2[5] = c[5] & ~n[5];
          n2 = n;
          n2[4] = keep;
          n2[7] = n[4] & ~keep;
          exp_mem[q][cf][7:0] = c2;
          exp_mem[q][nf][7:0] = n2;
          cnt++;
          break;
        end
      end
    end
  endtask
  task automatic drive(input int q, input int ct, input int fm, input int fi, input int fni, input int nc, input int nn);
    bus.queue_select = QW'(q);
    bus.cmd_type = 2'(ct);
    bus.full_match = fm != 0;
    bus.first_idx = SB'(fi);
    bus.first_next_idx = SB'(fni);
    bus.num_args_cur = AW'(nc);
    bus.num_args_next = AW'(nn);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.queue_select = QW'($urandom);
    bus.cmd_type = 2'($urandom);
    bus.full_match = 1'($urandom);
    bus.first_idx = SB'($urandom);
    bus.first_next_idx = SB'($urandom);
    bus.num_args_cur = AW'($urandom);
    bus.num_args_next = AW'($urandom);
  endtask
  task automatic run(input int q, input int ct, input int fm, input int fi, input int fni, input int nc, input int nn);
    int cnt, cyc, o0, wr;
    exp_mem = mem;
    model(q, ct, fm, fi, fni, nc, nn, cnt);
    o0 = obs_en.size();
    drive(q, ct, fm, fi, fni, nc, nn);
    cyc = 1;
    if (nc != 0 && nn != 0) chk("busy_after_start", 64'(bus.busy), 64'(1));
    while (!bus.finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("finished", 64'(bus.finished), 64'(1));
    chk("busy_at_finish", 64'(bus.busy), 64'(0));
    if (nc == 0 || nn == 0) begin
      chk("zero_latency", 64'(cyc), 64'(1));
      chk("zero_no_access", 64'(obs_en.size() - o0), 64'(0));
    end
    @(negedge clk);
    chk("finished_pulse", 64'(bus.finished), 64'(0));
    chk("match_count", 64'(bus.match_count), 64'(cnt));
    wr = 0;
    for (int k = o0; k < obs_en.size(); k++) begin
      chk("q_en_onehot", 64'(obs_en[k]), 64'(1) << q);
      if (obs_we[k] != 8'h00) begin
        wr++;
        chk("q_we", 64'(obs_we[k]), 64'h01);
      end
    end
    chk("write_count", 64'(wr), 64'(2*cnt));
    cmp_mem("run");
  endtask
  initial begin
    int q, ct, fm, fi, fni, nc, nn, rc, rn, hw, cyc;
    pool[0] = 64'h0000_0000_0000_1000;
    pool[1] = 64'h8000_0000_0000_1000;
    pool[2] = 64'h0000_0000_0000_2000;
    pool[3] = 64'h0000_0001_0000_2000;
    ld = 1'b0;
    ld_q = 0;
    ld_a = 0;
    ld_d = '0;
    bus.start = 1'b0;
    bus.queue_select = '0;
    bus.cmd_type = '0;
    bus.full_match = 1'b0;
    bus.first_idx = '0;
    bus.first_next_idx = '0;
    bus.num_args_cur = '0;
    bus.num_args_next = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_finished", 64'(bus.finished), 64'(0));
    chk("rst_q_en", 64'(bus.q_en), 64'(0));
    chk("rst_q_we", 64'(bus.q_we), 64'(0));
    chk("rst_match_count", 64'(bus.match_count), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NQ; k++)
      for (int a = 0; a < DEPTH; a++) poke(k, a, {$urandom, $urandom});
    // positional, one equal address pair
    set_arg(0, 3, 0, 8'h30, 64'h1000);
    set_arg(0, 3, 1, 8'h00, 64'h2222);
    set_arg(0, 19, 0, 8'h30, 64'h1000);
    set_arg(0, 19, 1, 8'h00, 64'h3333);
    run(0, 0, 0, 0, 16, 2, 2);
    chk("t1_cur_flags", 64'(mem[0][3][7:0]), 64'h10);
    chk("t1_next_flags", 64'(mem[0][19][7:0]), 64'hA0);
    // any-to-any on queue 1: cur {A,B,C}, next {C,A}
    for (int i = 0; i < 3; i++) set_arg(1, 24, i, 8'($urandom), 64'hA0 + 64'(i));
    set_arg(1, 34, 0, 8'($urandom), 64'hA2);
    set_arg(1, 34, 1, 8'($urandom), 64'hA0);
    run(1, 1, 1, 20, 30, 3, 2);
    // wrap across the top of the index space
    set_arg(0, 60, 0, 8'h00, 64'h111);
    set_arg(0, 60, 1, 8'h00, 64'h222);
    set_arg(0, 60, 2, 8'h20, 64'h5000);
    set_arg(0, 8, 0, 8'h00, 64'h999);
    set_arg(0, 8, 1, 8'h00, 64'h888);
    set_arg(0, 8, 2, 8'h30, 64'h5000);
    run(0, 1, 0, 56, 4, 3, 3);
    chk("t3_cur_flags_wrapped", 64'(mem[0][0][7:0]), 64'h00);
    chk("t3_next_flags", 64'(mem[0][12][7:0]), 64'h30);
    // zero-length next command right after a run that found matches
    run(0, 0, 1, 10, 40, 3, 0);
    // preserved low/bit6 flag bits
    set_arg(0, 34, 0, 8'h7F, 64'h7777);
    set_arg(0, 44, 0, 8'h5F, 64'h7777);
    run(0, 2, 0, 30, 40, 1, 1);
    chk("t5_cur_flags", 64'(mem[0][34][7:0]), 64'h7F);
    chk("t5_next_flags", 64'(mem[0][44][7:0]), 64'hCF);
    // reset during the first flag write
    set_arg(1, 13, 0, 8'h30, 64'h4242);
    set_arg(1, 33, 0, 8'h10, 64'h4242);
    exp_mem = mem;
    drive(1, 0, 0, 10, 30, 1, 1);
    cyc = 0;
    while (bus.q_we == 8'h00 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reached_write", 64'(cyc < 50), 64'(1));
    rstn = 1'b0;
    #1;
    chk("rst_mid_q_en", 64'(bus.q_en), 64'(0));
    chk("rst_mid_q_we", 64'(bus.q_we), 64'(0));
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    chk("rst_mid_finished", 64'(bus.finished), 64'(0));
    chk("rst_mid_match_count", 64'(bus.match_count), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    cmp_mem("rst_mid");
    run(1, 0, 0, 10, 30, 1, 1);
    // randomized commands
    for (int t = 0; t < 40; t++) begin
      q = $urandom_range(0, NQ - 1);
      ct = $urandom_range(0, 2);
      fm = $urandom_range(0, 1);
      nc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      nn = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      hw = (ct == 0) ? 3 : 4;
      rc = hw + 2*nc;
      rn = hw + 2*nn;
      fi = $urandom_range(0, DEPTH - 1);
      fni = (fi + rc + $urandom_range(0, DEPTH - rc - rn)) % DEPTH;
      for (int i = 0; i < nc; i++) set_arg(q, fi + hw, i, 8'($urandom), pool[$urandom_range(0, 3)]);
      for (int j = 0; j < nn; j++) set_arg(q, fni + hw, j, 8'($urandom), pool[$urandom_range(0, 3)]);
      run(q, ct, fm, fi, fni, nc, nn);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
